// File: rtl/bcd_game_timer.sv
// bcd_game_timer: multi-digit BCD up/down game timer with tick prescaler and
// a multiplexed active-low seven-segment scan driver.
`default_nettype none

module bcd_game_timer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 200_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  running,
  output logic                  over,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg
);

  localparam int VW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_n;
  logic [VW-1:0]   target, target_n, value_n, stepped, init_val;
  logic            mode_q, mode_n;
  logic [PW-1:0]   presc, presc_n;
  logic [SW-1:0]   scan_cnt;
  logic [IW-1:0]   scan_idx, idx_n;
  logic            scan_wrap;
  logic [3:0]      digit;

  function automatic logic [VW-1:0] clamp_bcd(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // Ripple a +1/-1 through the digits; carry/borrow stops at the first digit
  // that does not wrap.
  function automatic logic [VW-1:0] bcd_step(input logic [VW-1:0] v, input logic down);
    logic [VW-1:0] r;
    logic          c;
    logic [3:0]    d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (!down) begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: seg_decode = 7'h40;
      4'd1: seg_decode = 7'h79;
      4'd2: seg_decode = 7'h24;
      4'd3: seg_decode = 7'h30;
      4'd4: seg_decode = 7'h19;
      4'd5: seg_decode = 7'h12;
      4'd6: seg_decode = 7'h02;
      4'd7: seg_decode = 7'h78;
      4'd8: seg_decode = 7'h00;
      4'd9: seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign stepped  = bcd_step(value, mode_q);
  assign init_val = mode ? target : '0;

  always_comb begin
    state_n  = state;
    value_n  = value;
    target_n = target;
    mode_n   = mode_q;
    presc_n  = presc;
    case (state)
      IDLE, DONE: begin
        if (load) begin
          target_n = clamp_bcd(load_val);
          value_n  = mode ? clamp_bcd(load_val) : '0;
          state_n  = IDLE;
        end else if (start) begin
          mode_n  = mode;
          value_n = init_val;
          presc_n = '0;
          // Start value equals the terminal value in both modes exactly when target is zero.
          state_n = (target == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pause) begin
          state_n = PAUSE;
        end else if (presc == PW'(TICK_DIV - 1)) begin
          presc_n = '0;
          value_n = stepped;
          if (stepped == (mode_q ? '0 : target)) state_n = DONE;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      PAUSE: begin
        if (start && !pause) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      value   <= '0;
      target  <= '0;
      mode_q  <= 1'b0;
      presc   <= '0;
      running <= 1'b0;
      over    <= 1'b0;
    end else begin
      state   <= state_n;
      value   <= value_n;
      target  <= target_n;
      mode_q  <= mode_n;
      presc   <= presc_n;
      running <= (state_n == RUN);
      over    <= (state_n == DONE);
    end
  end

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  always_comb begin
    idx_n = scan_idx;
    if (scan_wrap)
      idx_n = (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
  end

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_n == IW'(i)) digit = value[4*i +: 4];
  end

  // dp follows the state every cycle so the pause indication is not delayed by the scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      sel      <= ~DIGITS'(1);
      seg      <= 8'hC0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      scan_idx <= idx_n;
      seg[7]   <= (state_n != PAUSE);
      if (scan_wrap) begin
        sel      <= ~(DIGITS'(1) << idx_n);
        seg[6:0] <= seg_decode(digit);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/bcd_game_timer.md
# bcd_game_timer

Parametrised multi-digit BCD game timer with an integrated count prescaler and a multiplexed seven-segment display driver. It counts up from zero to a loaded limit or down from a loaded value to zero, and supports start, pause/resume and reload. It flags expiry on `over` for the game-control FSM and drives the board's common-anode digit array directly. It supersedes the fixed 60-second counter, whose divider, counter and scan stages were separate modules.

## Interface
- `DIGITS`, default 4: number of BCD digits, display digits and `sel` lines (1..8).
- `TICK_DIV`, default 100_000_000: clk cycles per count step (1 s at 100 MHz); minimum 2.
- `SCAN_DIV`, default 200_000: clk cycles per display digit advance (2 ms at 100 MHz); minimum 2.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled each cycle; starts from IDLE/DONE and resumes from PAUSE.
- `pause` in 1: level-sampled; RUN -> PAUSE.
- `mode` in 1: 0 = count up, 1 = count down; latched on start from IDLE/DONE.
- `load` in 1: loads `load_val`; accepted only in IDLE or DONE.
- `load_val` in 4*DIGITS: BCD limit (up) or start value (down); digit 0 is the least-significant nibble.
- `value` out 4*DIGITS: current BCD count, registered.
- `running` out 1: high in RUN only.
- `over` out 1: high in DONE; held until the next load or start.
- `sel` out DIGITS: active-low one-hot digit enable.
- `seg` out 8: active-low segments `{dp,g,f,e,d,c,b,a}`.

## Operation
- **FSM states:** IDLE, RUN, PAUSE, DONE.
- **Reset values:** state IDLE; `value` = 0; `target` = 0; latched mode = up; prescaler = 0; scan index = 0; `over` = 0; `running` = 0; `sel` = ~1; `seg` = 8'hC0 ('0', dp off).
- **Load (IDLE/DONE only):**
  - `target` <= `load_val`, with each nibble > 9 clamped to 9.
  - `value` <= 0 if `mode` = 0, otherwise the clamped `target`.
  - `over` <= 0; state <= IDLE.
  - Load wins over a simultaneous start. Load in RUN/PAUSE is ignored.
- **Start from IDLE/DONE:**
  - Latch `mode`; reinitialise `value` as for load, using the held `target`; clear the prescaler.
  - If `value` already equals the terminal value (`target` for up, 0 for down), go directly to DONE. Otherwise go to RUN.
- **RUN:**
  - The prescaler counts 0..TICK_DIV-1; a tick occurs when it equals TICK_DIV-1, and it then wraps to 0.
  - On each tick, `value` steps by one in BCD: a digit at 9 wraps to 0 with carry (up), and a digit at 0 wraps to 9 with borrow (down).
  - If the new value equals the terminal value, state goes to DONE on the same edge.
  - `pause` -> PAUSE, with no tick on that edge, even if the prescaler is at TICK_DIV-1. Pause has priority over start. Start in RUN is ignored.
- **PAUSE:**
  - Prescaler and `value` are frozen.
  - `start` -> RUN, with the prescaler resuming from its held value. If `pause` and `start` are both high, the block stays in PAUSE.
- **DONE:** `value` is frozen at the terminal value; `over` = 1.
- Mode changes while RUN/PAUSE are ignored.
- **Scan:**
  - A free-running scan counter (0..SCAN_DIV-1) runs in every state.
  - At wrap, the scan index advances modulo DIGITS, and `sel`/`seg` register the new digit on that edge.
  - Segment decode: 0-9 use standard patterns; leading zeros are shown.
  - dp (`seg[7]`) = 0 on every digit while in PAUSE, 1 otherwise.
- A reset assertion at any point returns all state to the reset values immediately, with no clock required.

## Timing
- `start` sampled in IDLE at edge E: `running` = 1 after E. The first increment is visible after edge E+TICK_DIV, then one increment every TICK_DIV cycles.
- DONE entry: `over` = 1 and `running` = 0 on the same edge the terminal `value` appears; there is no extra cycle.
- Pause/resume: a run interrupted by PAUSE loses no prescaler cycles. The total RUN cycles needed to reach the next tick are unchanged.
- Display latency: `sel`/`seg` reflect `value` as sampled at the scan-wrap edge. The full refresh period is DIGITS*SCAN_DIV cycles.
- All outputs are registered; no combinational paths run from inputs to outputs.

## Test plan
- Parameters DIGITS=2, TICK_DIV=4, SCAN_DIV=3. Load 8'h12, mode=0, pulse start -> `value` steps 00,01,…,09,10,11,12 every 4 cycles. `over` rises with 12, then 12 is held; `running` falls on that edge.
- Load 8'h03, mode=1, start -> `value` 03,02,01,00 every 4 cycles, then `over`=1. Load 8'h10 in down mode -> steps 10 to 09 (borrow).
- Pause after 2 RUN cycles, hold for 10 cycles, then start -> next step occurs 2 RUN cycles after resume. dp is low on both digits during PAUSE.
- Load 8'h3F -> `target` = 8'h39 (clamp). Load 8'h00 then start -> DONE and `over`=1 on the next edge with no RUN. Load asserted during RUN -> ignored.
- Scan: `sel` sequence 2'b10, 2'b01, … every 3 cycles. With `value`=8'h47, `seg` = 8'h99 on digit 1 and 8'hF8 on digit 0.
- Assert `rst` low mid-RUN between clock edges -> all outputs reach their reset values immediately. After release, the block waits in IDLE.
